// File: rtl/detect_event_logger_pkg.sv
// detect_pkg: shared parameter defaults for the detection event logger
package detect_pkg;
  localparam int TS_W_DEF  = 12;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/detect_event_logger_fifo.sv
// event_fifo: first-word-fall-through timestamp FIFO with occupancy-based full/empty and drop detection
module event_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   occ;
  logic          do_wr, do_rd;
  assign full  = occ == (AW+1)'(DEPTH);
  assign empty = occ == '0;
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign drop  = wr && full && !do_rd;
  assign rdata = mem[rptr];
  // pointers and occupancy; clear wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      wptr <= do_wr ? wptr + 1'b1 : wptr;
      rptr <= do_rd ? rptr + 1'b1 : rptr;
      occ  <= occ + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  // storage is left unreset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/detect_event_logger.sv
// detect_event_logger: timestamps detector pulses into a FIFO, counts events and flags drops
module detect_event_logger import detect_pkg::*; #(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             clr,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [TS_W-1:0]  rd_data,
  output logic [CNT_W-1:0] evt_count,
  output logic             full,
  output logic             overflow
);
  logic [TS_W-1:0] ts;
  logic            empty, drop;
  assign rd_valid = !empty;
  event_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .wr    (det_in),
    .rd    (rd_en),
    .wdata (ts),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );
  // free-running timestamp, saturating event count and sticky drop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts        <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      ts        <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      ts        <= ts + 1'b1;
      evt_count <= (det_in && !(&evt_count)) ? evt_count + 1'b1 : evt_count;
      overflow  <= overflow | drop;
    end
  end
endmodule

// File: doc/detect_event_logger.md
DETECT_EVENT_LOGGER -- requirements
Module: detect_event_logger

Interface
REQ-001 Parameter TS_W, default 12: timestamp width in bits.
REQ-002 Parameter DEPTH, default 4: number of FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter CNT_W, default 8: width of the event counter in bits.
REQ-004 clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 det_in  input  1: detection pulse from the upstream Mealy sequence detector; each sampled-high cycle is one event.
REQ-007 clr  input  1: synchronous clear.
REQ-008 rd_en  input  1: read/pop request from the consumer.
REQ-009 rd_valid  output  1: FIFO non-empty; rd_data is valid.
REQ-010 rd_data  output  TS_W: timestamp at the FIFO head, first-word-fall-through.
REQ-011 evt_count  output  CNT_W: total events seen, saturating.
REQ-012 full  output  1: FIFO holds DEPTH entries.
REQ-013 overflow  output  1: sticky flag; at least one event was dropped.

Function
REQ-014 Free-running timestamp counter ts SHALL increment by 1 every cycle and wrap from 2^TS_W-1 to 0.
REQ-015 det_in=1 at edge k SHALL write the ts value held during cycle k into the FIFO.
- rd_valid and rd_data SHALL reflect the write from cycle k+1 onward (latency 1).
REQ-016 det_in=1 SHALL increment evt_count by 1 per cycle.
- evt_count SHALL hold at 2^CNT_W-1 with no wrap.
REQ-017 rd_en=1 with rd_valid=1 SHALL pop the head entry at the edge.
- rd_en=1 with rd_valid=0 SHALL have no effect.
REQ-018 Write when full and no simultaneous pop: the event SHALL be dropped and overflow SHALL be set.
- evt_count SHALL still increment.
REQ-019 Simultaneous write and pop when full: both SHALL occur; the entry count stays DEPTH and overflow is not set.
REQ-020 Simultaneous write and pop when holding 1 entry: the count stays 1 and rd_data shows the new timestamp next cycle.
REQ-021 FIFO order SHALL be strict FIFO.
- Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
- Full/empty SHALL be derived from an occupancy count of log2(DEPTH)+1 bits.
REQ-022 full SHALL equal (occupancy==DEPTH); rd_valid SHALL equal (occupancy!=0).
REQ-023 clr=1 SHALL take priority over det_in and rd_en. At the edge it SHALL:
- zero ts, evt_count, occupancy and both pointers;
- clear overflow;
- discard any det_in or rd_en in the same cycle.
REQ-024 overflow SHALL stay set until clr or reset.
REQ-025 rd_data SHALL be don't-care when rd_valid=0; the bench SHALL NOT check it.

Reset
REQ-026 rst low SHALL immediately, without waiting for clk, force:
- ts=0, evt_count=0, occupancy=0, pointers=0;
- overflow=0, full=0, rd_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents; nothing stored before reset SHALL be readable after it.
REQ-028 The first rising edge after rst deasserts SHALL be a normal operating edge.
REQ-029 FIFO storage array contents need not be reset.

Structure
REQ-030 Shared package detect_pkg SHALL hold the defaults of TS_W, DEPTH and CNT_W.
REQ-031 The FIFO SHALL be one sub-module, event_fifo, containing:
- storage, pointers and occupancy;
- outputs full, empty and overflow-on-drop.
REQ-032 The top level SHALL hold the timestamp counter, the event counter and the overflow flag, and instantiate event_fifo once.

Verification
REQ-033 Reset, then det_in high for 1 cycle when ts=5 -> next cycle: rd_valid=1, rd_data=5, evt_count=1.
REQ-034 Six det_in pulses with no reads, at ts=10,11,12,13,14,15 (DEPTH=4):
- after the fourth, full=1;
- after the fifth, overflow=1;
- evt_count=6;
- reading 4 times returns 10,11,12,13, then rd_valid=0.
REQ-035 Full FIFO, det_in=1 and rd_en=1 in the same cycle -> full stays 1, overflow stays 0, head advances by one entry.
REQ-036 240 cycles with det_in held high and rd_en held high (pops from the second cycle on) -> evt_count=240.
- Continue to 300 cycles -> evt_count=255, holding.
REQ-037 FIFO holding 2 entries, overflow=1, then clr=1 together with det_in=1 -> next cycle: rd_valid=0, evt_count=0, overflow=0, ts=0.
REQ-038 rst pulled low mid-cycle with 3 entries held -> rd_valid=0 and full=0 before the next clk edge; rd_valid stays 0 after release until a new det_in.
